// File: rtl/input_ram_seq.sv
// Pair-read sequencer: walks a burst of even-aligned word pairs out of a
// combinational dual-read RAM and hands each pair to a valid/ready consumer.
module input_ram_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [3:0]            pair_count,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addrs,
    input  logic [DATA_WIDTH-1:0] ram_data1,
    input  logic [DATA_WIDTH-1:0] ram_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [3:0]            remaining, remaining_nxt;
    logic                  xfer;
    logic                  unused_base_lsb;

    // Pairs are always even-aligned, so the low address bit is dropped.
    assign unused_base_lsb = base_addr[0];
    assign xfer            = (state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    addr_nxt      = {base_addr[ADDR_WIDTH-1:1], 1'b0};
                    remaining_nxt = pair_count;
                    state_nxt     = READ;
                end
            end
            READ: state_nxt = abort ? IDLE : HOLD;
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    if (remaining != 4'd0) begin
                        remaining_nxt = remaining - 4'd1;
                        addr_nxt      = addr + ADDR_WIDTH'(2);
                        state_nxt     = READ;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture only in READ; the pair then stays put through HOLD and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a <= '0;
            out_b <= '0;
        end else if (state == READ) begin
            out_a <= ram_data1;
            out_b <= ram_data2;
        end
    end

    assign ram_en    = (state == READ);
    assign ram_addrs = addr;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_input_ram_seq.sv
// Randomized bench for input_ram_seq: a pair-list reference model predicts
// the per-cycle handshake, addresses, data and done pulse of each burst.
module tb_input_ram_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  base_addr;
    logic [3:0]  pair_count;
    logic        ram_en;
    logic [4:0]  ram_addrs;
    logic [15:0] ram_data1;
    logic [15:0] ram_data2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        busy;
    logic        done;

    logic [15:0] mem [32];
    logic [4:0]  addr_p1;
    int          checks = 0;
    int          errors = 0;

    input_ram_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .pair_count(pair_count),
        .ram_en(ram_en), .ram_addrs(ram_addrs),
        .ram_data1(ram_data1), .ram_data2(ram_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .busy(busy), .done(done)
    );

    assign addr_p1   = ram_addrs + 5'd1;
    assign ram_data1 = mem[ram_addrs];
    assign ram_data2 = mem[addr_p1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic fill_ident();
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    endtask

    // Pair list: pair k lives at ({base[4:1],0} + 2k) mod 32. A pair is shown
    // 2 cycles after start or after the previous acceptance; done follows the last.
    task automatic run_burst(input logic [4:0] base, input logic [3:0] cnt,
                             input int stall, input bit noise, input string name);
        int         n, p, ref_c, fin, hold_n, stall_now, en_cnt, done_cnt;
        bit         exp_en, exp_val, exp_done, exp_busy, finished;
        logic [4:0] a0, cur, last;
        n = int'(cnt) + 1; p = 0; ref_c = 0; fin = -1; hold_n = 0;
        en_cnt = 0; done_cnt = 0; finished = 0;
        a0 = {base[4:1], 1'b0};
        last = a0;
        stall_now = (stall < 0) ? $urandom_range(0, 3) : stall;
        start = 1; abort = 0; base_addr = base; pair_count = cnt; out_ready = 0;
        for (int c = 1; c < 800; c++) begin
            @(negedge clk);
            start = 0;
            cur      = a0 + 5'(2 * p);
            exp_en   = (p < n) && (c == ref_c + 1);
            exp_val  = (p < n) && (c >= ref_c + 2);
            exp_done = (fin >= 0) && (c == fin + 1);
            exp_busy = (fin < 0) || (c <= fin + 1);
            if (ram_en) en_cnt++;
            if (done) done_cnt++;
            checks++;
            if (ram_en !== exp_en) begin
                errors++; $display("FAIL %s ram_en c=%0d got %b want %b", name, c, ram_en, exp_en);
            end
            checks++;
            if (exp_en) begin
                last = cur;
                if (ram_addrs !== cur) begin
                    errors++; $display("FAIL %s ram_addrs c=%0d got %0d want %0d", name, c, ram_addrs, cur);
                end
            end else if (ram_addrs !== last) begin
                errors++; $display("FAIL %s ram_addrs_hold c=%0d got %0d want %0d", name, c, ram_addrs, last);
            end
            checks++;
            if (out_valid !== exp_val) begin
                errors++; $display("FAIL %s out_valid c=%0d got %b want %b", name, c, out_valid, exp_val);
            end
            if (exp_val) begin
                checks++;
                if (out_a !== mem[cur] || out_b !== mem[cur + 5'd1]) begin
                    errors++;
                    $display("FAIL %s pair%0d c=%0d got (%0h,%0h) want (%0h,%0h)",
                             name, p, c, out_a, out_b, mem[cur], mem[cur + 5'd1]);
                end
            end
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL %s done c=%0d got %b want %b", name, c, done, exp_done);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL %s busy c=%0d got %b want %b", name, c, busy, exp_busy);
            end
            if (fin >= 0 && c == fin + 2) begin
                finished = 1;
                break;
            end
            if (exp_val) begin
                out_ready = (hold_n >= stall_now);
                if (out_ready) begin
                    ref_c = c;
                    if (p == n - 1) fin = c;
                    p++;
                    hold_n = 0;
                    stall_now = (stall < 0) ? $urandom_range(0, 3) : stall;
                end else begin
                    hold_n++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                base_addr = 5'($urandom);
                pair_count = 4'($urandom);
            end
        end
        start = 0; out_ready = 0;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL %s timeout: burst never completed", name);
        end
        checks++;
        if (en_cnt != n) begin
            errors++; $display("FAIL %s ram_en_pulses got %0d want %0d", name, en_cnt, n);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({ram_en, out_valid, busy, done} !== 4'b0 || ram_addrs !== 5'd0 ||
            out_a !== 16'd0 || out_b !== 16'd0) begin
            errors++;
            $display("FAIL %s en=%b val=%b busy=%b done=%b addr=%0d a=%0h b=%0h want all 0",
                     name, ram_en, out_valid, busy, done, ram_addrs, out_a, out_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1; abort = 0; base_addr = 5'd9; pair_count = 4'd3; out_ready = 0;
        #2;
        check_idle_zero("reset_t0");
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset_held");
        start = 0;
        rst_n = 1;
    endtask

    task automatic test_abort();
        fill_ident();
        start = 1; abort = 0; base_addr = 5'd12; pair_count = 4'd3; out_ready = 0;
        @(negedge clk); start = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'd12) begin
            errors++; $display("FAIL abort_hold1 val=%b a=%0d want 1,12", out_valid, out_a);
        end
        out_ready = 1;
        @(negedge clk); out_ready = 0;
        checks++;
        if (ram_en !== 1'b1 || ram_addrs !== 5'd14) begin
            errors++; $display("FAIL abort_read2 en=%b addr=%0d want 1,14", ram_en, ram_addrs);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_b !== 16'd15) begin
            errors++; $display("FAIL abort_hold2 val=%b b=%0d want 1,15", out_valid, out_b);
        end
        abort = 1; out_ready = 1;
        @(negedge clk); abort = 0; out_ready = 0;
        checks++;
        if ({out_valid, busy, done, ram_en} !== 4'b0) begin
            errors++; $display("FAIL abort_idle val=%b busy=%b done=%b en=%b want 0", out_valid, busy, done, ram_en);
        end
        start = 1; base_addr = 5'd21; pair_count = 4'd0;
        @(negedge clk); start = 0;
        checks++;
        if (ram_en !== 1'b1 || ram_addrs !== 5'd20) begin
            errors++; $display("FAIL abort_restart en=%b addr=%0d want 1,20", ram_en, ram_addrs);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'd20 || out_b !== 16'd21) begin
            errors++; $display("FAIL abort_repair val=%b a=%0d b=%0d want 1,20,21", out_valid, out_a, out_b);
        end
        out_ready = 1;
        @(negedge clk); out_ready = 0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL abort_redone got %b want 1", done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_reidle busy=%b done=%b want 0,0", busy, done);
        end
        start = 1; abort = 1; base_addr = 5'd2; pair_count = 4'd1;
        @(negedge clk); start = 0; abort = 0;
        checks++;
        if (busy !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL abort_wins_start busy=%b en=%b want 0,0", busy, ram_en);
        end
    endtask

    task automatic test_reset_mid();
        fill_ident();
        start = 1; base_addr = 5'd18; pair_count = 4'd5; out_ready = 1;
        @(negedge clk); start = 0;
        checks++;
        if (ram_en !== 1'b1 || ram_addrs !== 5'd18) begin
            errors++; $display("FAIL rstmid_read en=%b addr=%0d want 1,18", ram_en, ram_addrs);
        end
        #1 rst_n = 0;
        #1 check_idle_zero("rstmid_async");
        @(negedge clk);
        check_idle_zero("rstmid_held");
        rst_n = 1;
        run_burst(5'd10, 4'd0, 0, 0, "post_reset");
    endtask

    initial begin
        fill_ident();
        test_reset();
        run_burst(5'd4, 4'd2, 0, 0, "base4_cnt2");
        run_burst(5'd30, 4'd1, 0, 0, "wrap30");
        run_burst(5'd7, 4'd0, 0, 0, "odd7_single");
        run_burst(5'd0, 4'd15, 3, 0, "full_stall3");
        test_abort();
        test_reset_mid();
        for (int k = 0; k < 10; k++) begin
            fill_rand();
            run_burst(5'($urandom), 4'($urandom), -1, 1, "random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
